// File: rtl/kmcnpr_pkg.sv
// rtl/kmcnpr_pkg.sv - shared types and NPRC field positions for the KMC11 NPR engine
package kmcnpr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_ACK   = 3'd3,
        ST_WDROP = 3'd4
    } npr_state_t;

    localparam int NPRC_BYTEXFER = 7;
    localparam int NPRC_NPRO     = 4;
    localparam int NPRC_BAEI_HI  = 3;
    localparam int NPRC_BAEI_LO  = 2;
    localparam int NPRC_NLXFER   = 1;
    localparam int NPRC_NPRRQ    = 0;

endpackage

// File: rtl/kmc_npr_dma.sv
// rtl/kmc_npr_dma.sv - KMC11 NPR bus-master engine: one word/byte DMA cycle per request
module kmc_npr_dma
    import kmcnpr_pkg::*;
#(
    parameter int ADDRW = 18,
    parameter int DATAW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kmcINIT,
    input  logic             devREQI,
    output logic             devACKO,
    input  logic [7:0]       kmcNPRC,
    input  logic [15:0]      kmcIBA,
    input  logic [15:0]      kmcOBA,
    input  logic [1:0]       kmcOBAE,
    input  logic [DATAW-1:0] kmcOBD,
    output logic [DATAW-1:0] kmcIBD,
    output logic             busREQO,
    input  logic             busACKI,
    output logic             busHOLD,
    output logic             busREAD,
    output logic             busWRITE,
    output logic             busBYTE,
    output logic [ADDRW-1:0] busADDR,
    output logic [DATAW-1:0] busDATAO,
    input  logic [DATAW-1:0] busDATAI
);

    npr_state_t       state, state_next;
    logic             lat_dir;
    logic             lat_byte;
    logic             lat_hold;
    logic [ADDRW-1:0] lat_addr;
    logic [DATAW-1:0] lat_data;
    logic [DATAW-1:0] ibd;
    logic             in_req;
    logic             unused_nprc;

    assign unused_nprc = ^{kmcNPRC[6:5], kmcNPRC[NPRC_NPRRQ]};

    always_ff @(posedge clk) begin
        if (rst || kmcINIT) begin
            state    <= ST_IDLE;
            lat_dir  <= 1'b0;
            lat_byte <= 1'b0;
            lat_hold <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            ibd      <= '0;
        end else begin
            state <= state_next;
            // Request fields are sampled once here so the bus side never follows live register inputs
            if (state == ST_LATCH) begin
                lat_dir  <= kmcNPRC[NPRC_NPRO];
                lat_byte <= kmcNPRC[NPRC_BYTEXFER];
                lat_hold <= kmcNPRC[NPRC_NLXFER];
                lat_addr <= kmcNPRC[NPRC_NPRO] ? ADDRW'({kmcOBAE, kmcOBA})
                                               : ADDRW'({kmcNPRC[NPRC_BAEI_HI:NPRC_BAEI_LO], kmcIBA});
                lat_data <= kmcOBD;
            end
            // A byte read still loads the whole word; lane selection is the microcode's job
            if (state == ST_REQ && busACKI && !lat_dir) begin
                ibd <= busDATAI;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_req     = 1'b0;
        devACKO    = 1'b0;
        case (state)
            ST_IDLE:  if (devREQI) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_REQ;
            ST_REQ: begin
                in_req = 1'b1;
                // Acknowledge takes priority over a simultaneous NXM abort
                if (busACKI)       state_next = ST_ACK;
                else if (!devREQI) state_next = ST_IDLE;
            end
            ST_ACK: begin
                devACKO    = 1'b1;
                state_next = ST_WDROP;
            end
            ST_WDROP: if (!devREQI) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busREQO  = in_req;
    assign busREAD  = in_req & ~lat_dir;
    assign busWRITE = in_req & lat_dir;
    assign busBYTE  = in_req & lat_byte;
    assign busADDR  = in_req ? lat_addr : '0;
    assign busDATAO = in_req ? lat_data : '0;
    // Hold persists through IDLE so a chained transfer never releases the bus
    assign busHOLD  = lat_hold;
    assign kmcIBD   = ibd;

endmodule
